altmemddr_local_test_driver: RTL and testbench

Initiator for the DDR controller's local interface, driving local_* requests into the controller/PHY top on phy_clk. On start it writes an address-derived pattern over a word range, reads the range back and compares each returned word. It reports pass/fail, an error count and the first failing address, for board bring-up and self-test.

---
 rtl/altmemddr_drv_pkg.sv | 37 +++
 rtl/altmemddr_local_test_driver_if.sv | 34 +++
 rtl/altmemddr_drv_checker.sv | 46 ++++
 rtl/altmemddr_local_test_driver.sv | 214 +++++++++++++++++++++
 tb/tb_altmemddr_local_test_driver.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/altmemddr_drv_pkg.sv
// Shared types, default widths and the address-derived test pattern for the
// DDR local-interface test driver.
package altmemddr_drv_pkg;

   localparam int DRV_ADDR_W          = 23;
   localparam int DRV_DATA_W          = 64;
   localparam int DRV_BE_W            = 8;
   localparam int DRV_CNT_W           = 24;
   localparam int DRV_MAX_OUTSTANDING = 8;
`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
   localparam int DRV_TIMEOUT_CYC     = 65535;
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_INIT = 3'd1,
      WRITE     = 3'd2,
      WDRAIN    = 3'd3,
      READ      = 3'd4,
      RDRAIN    = 3'd5,
      DONE      = 3'd6
   } drv_state_e;

   // Upper half carries the address, lower half its complement, so stuck or
   // swapped address lines show up as data mismatches.
   function automatic logic [DRV_DATA_W-1:0] pattern(input logic [DRV_DATA_W-1:0] seed,
                                                     input logic [DRV_ADDR_W-1:0] a);
      logic [DRV_DATA_W/2-1:0] hi;
      logic [DRV_DATA_W/2-1:0] lo;
      hi = '0;
      lo = '0;
      hi[DRV_ADDR_W-1:0] = a;
      lo[DRV_ADDR_W-1:0] = ~a;
      return seed ^ {hi, lo};
   endfunction

endpackage

// File: rtl/altmemddr_local_test_driver_if.sv
// Local-interface bundle between the test driver (master) and the DDR
// controller (slave).
interface altmemddr_local_test_driver_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 64,
   parameter int BE_W   = 8
);
   logic [ADDR_W-1:0] local_address;
   logic              local_write_req;
   logic              local_read_req;
   logic              local_burstbegin;
   logic              local_size;
   logic [BE_W-1:0]   local_be;
   logic [DATA_W-1:0] local_wdata;
   logic              local_init_done;
   logic              local_ready;
   logic              local_wdata_req;
   logic [DATA_W-1:0] local_rdata;
   logic              local_rdata_valid;

   modport master (
      output local_address, local_write_req, local_read_req, local_burstbegin,
             local_size, local_be, local_wdata,
      input  local_init_done, local_ready, local_wdata_req, local_rdata,
             local_rdata_valid
   );

   modport slave (
      input  local_address, local_write_req, local_read_req, local_burstbegin,
             local_size, local_be, local_wdata,
      output local_init_done, local_ready, local_wdata_req, local_rdata,
             local_rdata_valid
   );
endinterface

// File: rtl/altmemddr_drv_checker.sv
// Read-back checker: compares returned words, keeps a saturating error count
// and records the address of the first mismatch of a run.
module altmemddr_drv_checker #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [DATA_W-1:0] expected_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [CNT_W-1:0]  error_count_o,
   output logic [ADDR_W-1:0] first_fail_addr_o
);
   logic [CNT_W-1:0]  err_q;
   logic [ADDR_W-1:0] ffa_q;
   logic              seen_q;
   logic              mismatch;

   assign mismatch = valid_i && (rdata_i != expected_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q  <= '0;
         ffa_q  <= '0;
         seen_q <= 1'b0;
      end else if (clear_i) begin
         err_q  <= '0;
         ffa_q  <= '0;
         seen_q <= 1'b0;
      end else if (mismatch) begin
         if (err_q != '1)
            err_q <= err_q + 1'b1;
         if (!seen_q) begin
            seen_q <= 1'b1;
            ffa_q  <= addr_i;
         end
      end
   end

   assign error_count_o     = err_q;
   assign first_fail_addr_o = ffa_q;
endmodule

// File: rtl/altmemddr_local_test_driver.sv
// Write/read-back memory test initiator on the DDR controller local interface.
// Build option ALTMEMDDR_DRV_TIMEOUT_EN adds a drain watchdog and timeout output.
module altmemddr_local_test_driver
   import altmemddr_drv_pkg::*;
#(
   parameter int ADDR_W          = DRV_ADDR_W,
   parameter int DATA_W          = DRV_DATA_W,
   parameter int BE_W            = DRV_BE_W,
   parameter int CNT_W           = DRV_CNT_W,
   parameter int MAX_OUTSTANDING = DRV_MAX_OUTSTANDING
`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
   , parameter int TIMEOUT_CYC   = DRV_TIMEOUT_CYC
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  num_words,
   input  logic [DATA_W-1:0] seed,
   altmemddr_local_test_driver_if.master local_if,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  error_count,
   output logic [ADDR_W-1:0] first_fail_addr
`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
   , output logic            timeout
`endif
);
   localparam int OS_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [2:0] S_IDLE      = IDLE;
   localparam logic [2:0] S_WAIT_INIT = WAIT_INIT;
   localparam logic [2:0] S_WRITE     = WRITE;
   localparam logic [2:0] S_WDRAIN    = WDRAIN;
   localparam logic [2:0] S_READ      = READ;
   localparam logic [2:0] S_RDRAIN    = RDRAIN;
   localparam logic [2:0] S_DONE      = DONE;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [CNT_W-1:0]  req_idx_q, req_idx_d;
   logic [CNT_W-1:0]  wdata_idx_q, wdata_idx_d;
   logic [CNT_W-1:0]  rcv_idx_q, rcv_idx_d;
   logic [OS_W-1:0]   os_q, os_d;

   logic              start_ok, in_wr, in_rd;
   logic              wr_acc, rd_acc, wd_take, rd_ret;
   logic [ADDR_W-1:0] wr_addr, rcv_addr;
   logic [DATA_W-1:0] rcv_expected;

   assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
   assign in_wr    = (state_q == S_WRITE) || (state_q == S_WDRAIN);
   assign in_rd    = (state_q == S_READ) || (state_q == S_RDRAIN);

   assign local_if.local_write_req  = (state_q == S_WRITE);
   assign local_if.local_read_req   = (state_q == S_READ) && (os_q < OS_W'(MAX_OUTSTANDING))
                                      && (req_idx_q < num_q);
   assign local_if.local_burstbegin = local_if.local_write_req | local_if.local_read_req;
   assign local_if.local_size       = 1'b1;
   assign local_if.local_be         = {BE_W{1'b1}};
   assign local_if.local_address    = base_q + ADDR_W'(req_idx_q);

   // Write data follows its own index so the controller may pull data late.
   assign wr_addr              = base_q + ADDR_W'(wdata_idx_q);
   assign local_if.local_wdata = in_wr ? DATA_W'(pattern(DRV_DATA_W'(seed_q), DRV_ADDR_W'(wr_addr)))
                                       : '0;

   assign wr_acc  = local_if.local_write_req && local_if.local_ready;
   assign rd_acc  = local_if.local_read_req && local_if.local_ready;
   assign wd_take = local_if.local_wdata_req && in_wr;
   assign rd_ret  = local_if.local_rdata_valid && in_rd && (rcv_idx_q != num_q);

   assign rcv_addr     = base_q + ADDR_W'(rcv_idx_q);
   assign rcv_expected = DATA_W'(pattern(DRV_DATA_W'(seed_q), DRV_ADDR_W'(rcv_addr)));

`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d;
`endif

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      num_d       = num_q;
      seed_d      = seed_q;
      req_idx_d   = req_idx_q;
      wdata_idx_d = wdata_idx_q;
      rcv_idx_d   = rcv_idx_q;
      os_d        = os_q;
      if (wr_acc || rd_acc)
         req_idx_d = req_idx_q + 1'b1;
      if (wd_take)
         wdata_idx_d = wdata_idx_q + 1'b1;
      if (rd_ret)
         rcv_idx_d = rcv_idx_q + 1'b1;
      if (rd_acc && !rd_ret)
         os_d = os_q + 1'b1;
      else if (!rd_acc && rd_ret)
         os_d = os_q - 1'b1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               base_d      = base_addr;
               num_d       = num_words;
               seed_d      = seed;
               req_idx_d   = '0;
               wdata_idx_d = '0;
               rcv_idx_d   = '0;
               os_d        = '0;
               state_d     = S_WAIT_INIT;
            end
         end
         S_WAIT_INIT: begin
            if (local_if.local_init_done)
               state_d = (num_q == '0) ? S_DONE : S_WRITE;
         end
         S_WRITE: begin
            if (wr_acc && req_idx_q == num_q - 1'b1)
               state_d = S_WDRAIN;
         end
         S_WDRAIN: begin
            if (wdata_idx_q == num_q) begin
               req_idx_d   = '0;
               wdata_idx_d = '0;
               rcv_idx_d   = '0;
               state_d     = S_READ;
            end
         end
         S_READ: begin
            if (rd_acc && req_idx_q == num_q - 1'b1)
               state_d = S_RDRAIN;
         end
         S_RDRAIN: begin
            if (rcv_idx_q == num_q)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
      wd_d      = '0;
      timeout_d = start_ok ? 1'b0 : timeout_q;
      if ((state_q == S_WDRAIN || state_q == S_RDRAIN) && state_d == state_q) begin
         if (local_if.local_wdata_req || local_if.local_rdata_valid)
            wd_d = '0;
         else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
         end else
            wd_d = wd_q + 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         num_q       <= '0;
         seed_q      <= '0;
         req_idx_q   <= '0;
         wdata_idx_q <= '0;
         rcv_idx_q   <= '0;
         os_q        <= '0;
`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
         wd_q        <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         num_q       <= num_d;
         seed_q      <= seed_d;
         req_idx_q   <= req_idx_d;
         wdata_idx_q <= wdata_idx_d;
         rcv_idx_q   <= rcv_idx_d;
         os_q        <= os_d;
`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
         wd_q        <= wd_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   altmemddr_drv_checker #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_checker (
      .clk               (clk),
      .rst               (reset),
      .clear_i           (start_ok),
      .valid_i           (rd_ret),
      .rdata_i           (local_if.local_rdata),
      .expected_i        (rcv_expected),
      .addr_i            (rcv_addr),
      .error_count_o     (error_count),
      .first_fail_addr_o (first_fail_addr)
   );

   assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done = (state_q == S_DONE);
`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
   assign timeout = timeout_q;
   assign pass    = done && (error_count == '0) && !timeout_q;
`else
   assign pass    = done && (error_count == '0);
`endif
endmodule

// File: tb/tb_altmemddr_local_test_driver.sv
// Self-checking bench: a behavioural DDR controller model with a word memory
// answers the driver; results are compared against expectations from the bench.
module tb_altmemddr_local_test_driver;
   localparam int ADDR_W = 23;
   localparam int DATA_W = 64;
   localparam int BE_W   = 8;
   localparam int CNT_W  = 24;
   localparam int MAXO   = 8;
   localparam int unsigned AMASK = 32'h007F_FFFF;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  num_words = '0;
   logic [DATA_W-1:0] seed = '0;
   logic              busy, done, pass;
   logic [CNT_W-1:0]  error_count;
   logic [ADDR_W-1:0] first_fail_addr;
`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
   logic              timeout;
`endif

   altmemddr_local_test_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) lif ();

   altmemddr_local_test_driver #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .CNT_W(CNT_W), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .base_addr       (base_addr),
      .num_words       (num_words),
      .seed            (seed),
      .local_if        (lif),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .error_count     (error_count),
      .first_fail_addr (first_fail_addr)
`ifdef ALTMEMDDR_DRV_TIMEOUT_EN
      , .timeout       (timeout)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Controller model state and run logs
   int          ready_mode = 0;
   bit          toggle_ph = 1'b0;
   int          rd_lat = 1;
   int          corrupt_a = -1;
   int          corrupt_b = -1;
   bit          stray = 1'b0;
   int          cyc = 0;
   logic [63:0] mem [int];
   int          wq[$];
   int          rq_due[$];
   int          rq_addr[$];
   int          wr_log[$];
   int          rd_log[$];
   int          wr_acc_n, rd_acc_n, rd_ret_n;
   int          os_max, os_viol, hold_viol, req_seen, const_viol;
   bit          pend_hold = 1'b0;
   int          hold_addr;
   int          r_os, r_a;
   logic [63:0] r_d;

   function automatic logic [63:0] exp_pat(input logic [63:0] s, input int unsigned a);
      logic [63:0] av;
      av = 64'(a & AMASK);
      return s ^ (av << 32) ^ (av ^ 64'h0000_0000_007F_FFFF);
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         wq.delete(); rq_due.delete(); rq_addr.delete();
         pend_hold = 1'b0;
         lif.local_ready       = 1'b0;
         lif.local_wdata_req   = 1'b0;
         lif.local_rdata_valid = 1'b0;
         lif.local_rdata       = '0;
      end else begin
         if (lif.local_burstbegin !== (lif.local_write_req | lif.local_read_req) ||
             lif.local_size !== 1'b1 || lif.local_be !== 8'hFF)
            const_viol++;
         if (lif.local_write_req || lif.local_read_req)
            req_seen++;
         if (pend_hold && (!lif.local_write_req || int'(lif.local_address) != hold_addr))
            hold_viol++;
         r_os = rd_acc_n - rd_ret_n;
         if (r_os > os_max) os_max = r_os;
         if (r_os >= MAXO && lif.local_read_req) os_viol++;

         lif.local_wdata_req = 1'b0;
         if (stray)
            lif.local_wdata_req = 1'b1;
         else if (wq.size() > 0 && $urandom_range(3) != 0) begin
            lif.local_wdata_req = 1'b1;
            r_a = wq.pop_front();
            mem[r_a] = lif.local_wdata;
         end

         lif.local_rdata_valid = 1'b0;
         lif.local_rdata       = {$urandom, $urandom};
         if (stray)
            lif.local_rdata_valid = 1'b1;
         else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            void'(rq_due.pop_front());
            r_a = rq_addr.pop_front();
            r_d = mem.exists(r_a) ? mem[r_a] : 64'hDEAD_BEEF_0BAD_F00D;
            if (rd_ret_n == corrupt_a || rd_ret_n == corrupt_b)
               r_d[0] = ~r_d[0];
            lif.local_rdata_valid = 1'b1;
            lif.local_rdata       = r_d;
            rd_ret_n++;
         end

         case (ready_mode)
            0: lif.local_ready = 1'b1;
            1: begin lif.local_ready = toggle_ph; toggle_ph = ~toggle_ph; end
            default: lif.local_ready = ($urandom_range(1) == 1);
         endcase
         if (lif.local_write_req && lif.local_ready) begin
            wq.push_back(int'(lif.local_address));
            wr_log.push_back(int'(lif.local_address));
            wr_acc_n++;
         end
         if (lif.local_read_req && lif.local_ready) begin
            rq_due.push_back(cyc + rd_lat);
            rq_addr.push_back(int'(lif.local_address));
            rd_log.push_back(int'(lif.local_address));
            rd_acc_n++;
         end
         pend_hold = lif.local_write_req && !lif.local_ready;
         hold_addr = int'(lif.local_address);
      end
   end

   task automatic set_env(input int mode, input int lat, input int ca, input int cb);
      ready_mode = mode; rd_lat = lat; corrupt_a = ca; corrupt_b = cb;
   endtask

   task automatic start_pulse(input int unsigned b, input int unsigned n, input logic [63:0] s);
      wq.delete(); rq_due.delete(); rq_addr.delete(); mem.delete();
      wr_log.delete(); rd_log.delete();
      wr_acc_n = 0; rd_acc_n = 0; rd_ret_n = 0;
      os_max = 0; os_viol = 0; hold_viol = 0; req_seen = 0; const_viol = 0;
      @(negedge clk);
      base_addr = ADDR_W'(b); num_words = CNT_W'(n); seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int i;
      i = 0;
      while (done !== 1'b1 && i < budget) begin
         @(negedge clk);
         i++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done-timeout: done=%b required 1", name, done);
      end else
         $display("run %s: base=%h n=%0d err=%0d first_fail=%h pass=%b wr=%0d rd=%0d",
                  name, base_addr, num_words, error_count, first_fail_addr, pass, wr_acc_n, rd_ret_n);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({lif.local_write_req, lif.local_read_req, lif.local_burstbegin, lif.local_size,
           lif.local_be, lif.local_address} !== {4'b0001, 8'hFF, 23'h0}) begin
         errors++;
         $display("FAIL reset_req: got %b/%b/%b/%b be=%h addr=%h required 0/0/0/1 be=ff addr=0",
                  lif.local_write_req, lif.local_read_req, lif.local_burstbegin,
                  lif.local_size, lif.local_be, lif.local_address);
      end
      checks++;
      if ({busy, done, pass, error_count, first_fail_addr, lif.local_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_status: busy=%b done=%b pass=%b err=%0d ffa=%h wdata=%h required all 0",
                  busy, done, pass, error_count, first_fail_addr, lif.local_wdata);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_init_wait();
      int bad;
      set_env(0, 1, -1, -1);
      lif.local_init_done = 1'b0;
      start_pulse(0, 16, 64'h0);
      repeat (100) @(negedge clk);
      checks++;
      if (req_seen !== 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL init_wait: requests=%0d busy=%b required 0 requests busy=1", req_seen, busy);
      end
      lif.local_init_done = 1'b1;
      wait_done("init_wait", 2000);
      checks++;
      if (pass !== 1'b1 || error_count !== 0 || wr_acc_n != 16 || rd_ret_n != 16) begin
         errors++;
         $display("FAIL init_result: pass=%b err=%0d wr=%0d rd=%0d required 1 0 16 16",
                  pass, error_count, wr_acc_n, rd_ret_n);
      end
      bad = 0;
      for (int i = 0; i < 16; i++)
         if (!mem.exists(i) || mem[i] !== exp_pat(64'h0, i)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL init_wdata: %0d bad words required 0", bad);
      end
   endtask

   task automatic test_ready_toggle();
      set_env(1, 3, -1, -1);
      start_pulse(0, 8, {$urandom, $urandom});
      wait_done("ready_toggle", 2000);
      checks++;
      if (wr_acc_n != 8) begin
         errors++;
         $display("FAIL toggle_count: write acceptances=%0d required 8", wr_acc_n);
      end
      for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
         checks++;
         if (wr_log[i] != i) begin
            errors++;
            $display("FAIL toggle_addr[%0d]: got %h required %h", i, wr_log[i], i);
         end
      end
      checks++;
      if (hold_viol != 0 || const_viol != 0 || pass !== 1'b1) begin
         errors++;
         $display("FAIL toggle_hold: hold_viol=%0d const_viol=%0d pass=%b required 0 0 1",
                  hold_viol, const_viol, pass);
      end
   endtask

   task automatic test_error_inject();
      set_env(2, 2, 5, -1);
      start_pulse(32'h100, 10, {$urandom, $urandom});
      wait_done("error_inject", 2000);
      checks++;
      if (error_count !== 1 || first_fail_addr !== 23'h105 || pass !== 1'b0) begin
         errors++;
         $display("FAIL error_inject: err=%0d ffa=%h pass=%b required 1 105 0",
                  error_count, first_fail_addr, pass);
      end
   endtask

   task automatic test_latency();
      set_env(0, 20, -1, -1);
      start_pulse($urandom & AMASK, 32, {$urandom, $urandom});
      wait_done("latency", 3000);
      checks++;
      if (os_max != MAXO || os_viol != 0) begin
         errors++;
         $display("FAIL latency_outstanding: max=%0d over_issue=%0d required 8 0", os_max, os_viol);
      end
      checks++;
      if (rd_ret_n != 32 || error_count !== 0 || pass !== 1'b1) begin
         errors++;
         $display("FAIL latency_result: returned=%0d err=%0d pass=%b required 32 0 1",
                  rd_ret_n, error_count, pass);
      end
   endtask

   task automatic test_wrap();
      int exp_a [4];
      exp_a = '{32'h7FFFFE, 32'h7FFFFF, 0, 1};
      set_env(2, 4, -1, -1);
      start_pulse(32'h7FFFFE, 4, {$urandom, $urandom});
      wait_done("wrap", 2000);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wr_log.size() || i >= rd_log.size() || wr_log[i] != exp_a[i] || rd_log[i] != exp_a[i]) begin
            errors++;
            $display("FAIL wrap_addr[%0d]: wr=%h rd=%h required %h", i,
                     (i < wr_log.size()) ? wr_log[i] : -1, (i < rd_log.size()) ? rd_log[i] : -1, exp_a[i]);
         end
      end
      checks++;
      if (pass !== 1'b1 || !mem.exists(0) || mem[0] !== exp_pat(seed, 0)) begin
         errors++;
         $display("FAIL wrap_result: pass=%b required 1 with wrapped word 0 written", pass);
      end
   endtask

   task automatic test_random();
      int unsigned b, n, exp_ffa;
      int ca, cb, first, exp_err;
      logic [63:0] s;
      for (int it = 0; it < 6; it++) begin
         b  = $urandom & AMASK;
         n  = $urandom_range(40, 1);
         s  = {$urandom, $urandom};
         ca = ($urandom_range(2) == 0) ? -1 : int'($urandom_range(n - 1));
         cb = ($urandom_range(2) == 0) ? -1 : int'($urandom_range(n - 1));
         if (cb == ca) cb = -1;
         set_env(2, $urandom_range(12, 1), ca, cb);
         start_pulse(b, n, s);
         wait_done("random", 4000);
         exp_err = (ca >= 0 ? 1 : 0) + (cb >= 0 ? 1 : 0);
         first = (ca >= 0 && (cb < 0 || ca < cb)) ? ca : cb;
         exp_ffa = (first >= 0) ? ((b + first) & AMASK) : 0;
         checks++;
         if (int'(error_count) != exp_err || int'(first_fail_addr) != int'(exp_ffa) ||
             pass !== (exp_err == 0) || os_viol != 0) begin
            errors++;
            $display("FAIL random[%0d]: err=%0d ffa=%h pass=%b required %0d %h %b",
                     it, error_count, first_fail_addr, pass, exp_err, exp_ffa, exp_err == 0);
         end
      end
   endtask

   task automatic test_stray();
      logic [CNT_W-1:0]  e0;
      logic [ADDR_W-1:0] f0;
      e0 = error_count;
      f0 = first_fail_addr;
      @(negedge clk);
      stray = 1'b1;
      repeat (5) @(negedge clk);
      stray = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (error_count !== e0 || first_fail_addr !== f0 || done !== 1'b1) begin
         errors++;
         $display("FAIL stray: err=%0d ffa=%h done=%b required %0d %h 1",
                  error_count, first_fail_addr, done, e0, f0);
      end
   endtask

   task automatic test_reset_mid();
      int i;
      set_env(0, 20, -1, -1);
      start_pulse(32'h40, 64, {$urandom, $urandom});
      i = 0;
      while (lif.local_read_req !== 1'b1 && i < 2000) begin
         @(negedge clk);
         i++;
      end
      checks++;
      if (lif.local_read_req !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_reach_read: read_req=%b required 1", lif.local_read_req);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({lif.local_write_req, lif.local_read_req, lif.local_burstbegin, lif.local_size,
           lif.local_be, lif.local_wdata, busy, done, pass, error_count, first_fail_addr}
          !== {4'b0001, 8'hFF, 64'h0, 3'b000, 24'h0, 23'h0}) begin
         errors++;
         $display("FAIL reset_mid_values: wr=%b rd=%b busy=%b done=%b err=%0d required reset values",
                  lif.local_write_req, lif.local_read_req, busy, done, error_count);
      end
      lif.local_init_done = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      start_pulse(0, 0, 64'h0);
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL zero_wait_init: busy=%b done=%b required 1 0", busy, done);
      end
      lif.local_init_done = 1'b1;
      wait_done("zero_words", 50);
      checks++;
      if (pass !== 1'b1 || error_count !== 0 || req_seen != 0) begin
         errors++;
         $display("FAIL zero_words: pass=%b err=%0d requests=%0d required 1 0 0",
                  pass, error_count, req_seen);
      end
   endtask

   initial begin
      lif.local_init_done = 1'b0;
      test_reset();
      test_init_wait();
      test_ready_toggle();
      test_error_inject();
      test_latency();
      test_wrap();
      test_random();
      test_stray();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "global timeout");
   end
endmodule
